// File: rtl/pico_mips_mc.sv
`default_nettype none
// pico_mips_mc -- single-cycle pico MIPS core with IN/OUT valid-ready handshakes, rev 1.0.
// MULI (signed Q1.(N-1) multiply) is present only when PICO_MIPS_MC_MULT_EN is defined.
module pico_mips_mc #(
  parameter  int N     = 8,
  parameter  int NREGS = 8,
  parameter  int PA    = 6,
  localparam int RA    = $clog2(NREGS),
  localparam int IW    = 4 + 2*RA + N
) (
  input  logic          clk,
  input  logic          n_reset,
  output logic [PA-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          halted
);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SUBI = 4'd4;
`ifdef PICO_MIPS_MC_MULT_EN
  localparam logic [3:0] OP_MULI = 4'd5;
`endif
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_IN   = 4'd8;
  localparam logic [3:0] OP_OUT  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t        state_q, state_d;
  logic [PA-1:0] pc_q, pc_d;
  logic          zf_q, zf_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  regs_q [NREGS];

  logic [3:0]    op;
  logic [RA-1:0] rd, rs;
  logic [N-1:0]  imm, rd_val, rs_val, alu_res, wr_data;
  logic          alu_op, wr_en, in_ready_c;
  logic [PA-1:0] pc_inc, pc_br;

  assign op     = prog_data[IW-1 -: 4];
  assign rd     = prog_data[IW-5 -: RA];
  assign rs     = prog_data[IW-5-RA -: RA];
  assign imm    = prog_data[N-1:0];
  assign rd_val = (rd == '0) ? '0 : regs_q[rd];
  assign rs_val = (rs == '0) ? '0 : regs_q[rs];
  assign pc_inc = pc_q + PA'(1);
  // Sign extension of the offset is a no-op once the sum wraps at PA bits.
  assign pc_br  = pc_q + imm[PA-1:0];

`ifdef PICO_MIPS_MC_MULT_EN
  logic signed [2*N-1:0] prod;
  assign prod = $signed(rd_val) * $signed(imm);
`endif

  always_comb begin
    alu_op  = 1'b1;
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_ADDI: alu_res = rd_val + imm;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_SUBI: alu_res = rd_val - imm;
`ifdef PICO_MIPS_MC_MULT_EN
      OP_MULI: alu_res = prod[2*N-2:N-1];
`endif
      default: alu_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    zf_d        = zf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    wr_en       = 1'b0;
    wr_data     = alu_res;
    in_ready_c  = 1'b0;
    if (state_q == S_RUN) begin
      pc_d = pc_inc;
      if (alu_op) begin
        wr_en = 1'b1;
        zf_d  = (alu_res == '0);
      end else begin
        case (op)
          OP_BEQ: if (zf_q)  pc_d = pc_br;
          OP_BNE: if (!zf_q) pc_d = pc_br;
          OP_IN: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
              wr_en   = 1'b1;
              wr_data = in_data;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_OUT: begin
            if (!out_valid_q || out_ready) begin
              out_data_d  = rs_val;
              out_valid_d = 1'b1;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_HALT: begin
            state_d = S_HALTED;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_RUN;
      pc_q        <= '0;
      zf_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      zf_q        <= zf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      if (wr_en && rd != '0) regs_q[rd] <= wr_data;
    end
  end

  // in_ready must read low the instant reset is asserted, even over an IN opcode.
  assign in_ready  = in_ready_c & n_reset;
  assign prog_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pico_mips_mc.sv
`default_nettype none
// tb_pico_mips_mc -- directed scenarios plus random programs checked against an instruction-level model.
module tb_pico_mips_mc;
  localparam int N = 8, NREGS = 8, PA = 6, IW = 18;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [PA-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          halted;

  logic [IW-1:0] prog [64];
  assign prog_data = prog[prog_addr];

  always #5 clk = ~clk;

  pico_mips_mc #(.N(N), .NREGS(NREGS), .PA(PA)) dut (
    .clk(clk), .n_reset(n_reset), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  int n_tests = 0, n_fail = 0;
  int m_pc, m_zf, m_ov, m_od, m_halt;
  int m_r [8];
  logic ir_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int rd, input int rs, input int imm);
    return {op[3:0], rd[2:0], rs[2:0], imm[7:0]};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_zf = 0; m_ov = 0; m_od = 0; m_halt = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endtask

  function automatic int cur_op();
    logic [IW-1:0] ir;
    ir = prog[m_pc];
    return int'(ir[17:14]);
  endfunction

  // One clock of architectural behaviour, using the inputs that will be present at the edge.
  task automatic model_step();
    logic [IW-1:0] ir;
    int op, rd, rs, imm, a, b, res, npc, nov, off, sa, si;
    bit wr, alu;
    ir  = prog[m_pc];
    op  = int'(ir[17:14]); rd = int'(ir[13:11]); rs = int'(ir[10:8]); imm = int'(ir[7:0]);
    a   = (rd == 0) ? 0 : m_r[rd];
    b   = (rs == 0) ? 0 : m_r[rs];
    res = 0; wr = 0; alu = 0;
    npc = (m_pc + 1) % 64;
    nov = (m_ov != 0 && !out_ready) ? 1 : 0;
    if (m_halt == 0) begin
      case (op)
        1: begin res = a + b;   alu = 1; end
        2: begin res = a + imm; alu = 1; end
        3: begin res = a - b;   alu = 1; end
        4: begin res = a - imm; alu = 1; end
`ifdef PICO_MIPS_MC_MULT_EN
        5: begin
          sa = (a > 127) ? a - 256 : a;
          si = (imm > 127) ? imm - 256 : imm;
          res = (sa * si) >>> 7; alu = 1;
        end
`endif
        6, 7: begin
          if ((op == 6) == (m_zf != 0)) begin
            off = imm % 64;
            if (off >= 32) off = off - 64;
            npc = (m_pc + off + 64) % 64;
          end
        end
        8: if (in_valid) begin res = int'(in_data); wr = 1; end else npc = m_pc;
        9: if (m_ov == 0 || out_ready) begin m_od = b; nov = 1; end else npc = m_pc;
        15: begin m_halt = 1; npc = m_pc; end
        default: ;
      endcase
      if ((alu || wr) && rd != 0) m_r[rd] = res & 255;
      if (alu) m_zf = ((res & 255) == 0) ? 1 : 0;
      m_pc = npc;
    end
    m_ov = nov;
  endtask

  task automatic run_cycle();
    #1;
    check_eq("pc", prog_addr, m_pc);
    check_eq("in_ready", in_ready, (m_halt == 0 && cur_op() == 8) ? 1 : 0);
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_data", out_data, m_od);
    check_eq("halted", halted, m_halt);
    ir_seen = in_ready;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 n_reset = 1'b0;
    #1;
    check_eq("rst_halted", halted, 0);
    check_eq("rst_pc", prog_addr, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 0);
    model_reset();
    #1 n_reset = 1'b1;
  endtask

  initial begin
    int hi, op;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();

    // Zero flag via ADDI/SUBI, then taken BEQ from 2 to 5.
    clear_prog();
    prog[0] = ins(2, 1, 0, 5); prog[1] = ins(4, 1, 0, 5);
    prog[2] = ins(6, 0, 0, 3); prog[5] = ins(9, 0, 1, 0);
    do_reset();
    repeat (3) run_cycle();
    check_eq("beq_target", prog_addr, 5);
    run_cycle();
    check_eq("beq_r1", out_data, 0);

    // IN stall for 4 cycles, then accept 0x2A.
    clear_prog();
    prog[0] = ins(8, 2, 0, 0); prog[1] = ins(9, 0, 2, 0);
    do_reset();
    hi = 0;
    repeat (4) begin run_cycle(); if (ir_seen) hi++; end
    check_eq("in_stall_pc", prog_addr, 0);
    in_valid = 1'b1; in_data = 8'h2A;
    run_cycle(); if (ir_seen) hi++;
    in_valid = 1'b0;
    check_eq("in_done_pc", prog_addr, 1);
    out_ready = 1'b1;
    run_cycle();
    check_eq("in_r2", out_data, 8'h2A);
    check_eq("in_ready_cycles", hi, 5);

    // Back-to-back OUT under backpressure.
    clear_prog();
    prog[0] = ins(2, 1, 0, 8'h11); prog[1] = ins(2, 2, 0, 8'h22);
    prog[2] = ins(9, 0, 1, 0);     prog[3] = ins(9, 0, 2, 0);
    out_ready = 1'b0;
    do_reset();
    repeat (5) run_cycle();
    check_eq("out_stall_pc", prog_addr, 3);
    check_eq("out_hold_data", out_data, 8'h11);
    check_eq("out_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    run_cycle();
    out_ready = 1'b0;
    check_eq("out_second_data", out_data, 8'h22);
    check_eq("out_second_valid", out_valid, 1);
    check_eq("out_second_pc", prog_addr, 4);

    // Backward BNE wrap to 63, then NOP wraps to 0.
    clear_prog();
    prog[1] = ins(7, 0, 0, 8'h3E);
    do_reset();
    repeat (2) run_cycle();
    check_eq("bne_to_63", prog_addr, 63);
    run_cycle();
    check_eq("pc_wrap_0", prog_addr, 0);

    // MULI 0.5 * 0.5.
    clear_prog();
    prog[0] = ins(2, 3, 0, 8'h40); prog[1] = ins(5, 3, 0, 8'h40); prog[2] = ins(9, 0, 3, 0);
    out_ready = 1'b1;
    do_reset();
    repeat (3) run_cycle();
`ifdef PICO_MIPS_MC_MULT_EN
    check_eq("muli_r3", out_data, 8'h20);
`else
    check_eq("muli_r3", out_data, 8'h40);
`endif

    // HALT with a pending output, then asynchronous reset.
    clear_prog();
    prog[0] = ins(2, 1, 0, 7); prog[1] = ins(9, 0, 1, 0); prog[2] = ins(15, 0, 0, 0);
    out_ready = 1'b0;
    do_reset();
    repeat (6) run_cycle();
    check_eq("halt_flag", halted, 1);
    check_eq("halt_pc", prog_addr, 2);
    check_eq("halt_out_pending", out_valid, 1);
    do_reset();

    // Random programs with random handshake traffic.
    repeat (20) begin
      for (int i = 0; i < 64; i++) begin
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 7) != 0) op = 2;
        prog[i] = ins(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      do_reset();
      repeat (150) begin
        in_valid  = ($urandom_range(0, 1) == 1);
        in_data   = N'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
        run_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
